lcd1602_responder: RTL

LCD1602_RESPONDER -- requirements
Module: lcd1602_responder

---
 rtl/lcd1602_pkg.sv | 55 +++++
 rtl/lcd1602_responder_if.sv | 12 +
 rtl/lcd1602_bus_sync.sv | 50 +++++
 rtl/lcd1602_responder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/lcd1602_pkg.sv
// lcd1602_pkg: instruction bits, DDRAM address map, state enum and address helpers
// shared by the LCD1602 responder files.
package lcd1602_pkg;
    localparam int B_CLEAR = 0;
    localparam int B_HOME  = 1;
    localparam int B_ENTRY = 2;
    localparam int B_DISP  = 3;
    localparam int B_SHIFT = 4;
    localparam int B_FUNC  = 5;
    localparam int B_CGRAM = 6;
    localparam int B_DDRAM = 7;
    localparam int B_ID    = 1;
    localparam int B_RL    = 2;
    localparam int B_SC    = 3;
    localparam int B_DL    = 4;

    localparam logic [6:0] LINE1_BASE = 7'h00;
    localparam logic [6:0] LINE1_LAST = 7'h27;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam logic [6:0] LINE2_LAST = 7'h67;
    localparam int         LINE_LEN    = 40;
    localparam int         DDRAM_DEPTH = 80;
    localparam logic [7:0] BLANK       = 8'h20;

    typedef enum logic [1:0] {IDLE, SWEEP, BUSY} state_e;

    typedef enum logic [3:0] {
        I_NONE, I_CLEAR, I_HOME, I_ENTRY, I_DISP, I_SHIFT, I_FUNC, I_CGRAM, I_DDRAM
    } instr_e;

    function automatic instr_e decode_instr(input logic [7:0] b);
        return b[B_DDRAM] ? I_DDRAM :
               b[B_CGRAM] ? I_CGRAM :
               b[B_FUNC]  ? I_FUNC  :
               b[B_SHIFT] ? I_SHIFT :
               b[B_DISP]  ? I_DISP  :
               b[B_ENTRY] ? I_ENTRY :
               b[B_HOME]  ? I_HOME  :
               b[B_CLEAR] ? I_CLEAR : I_NONE;
    endfunction

    // Both lines share the same low-6-bit range, so bit 6 only picks the line.
    function automatic logic ac_valid(input logic [6:0] a);
        return a[5:0] <= LINE1_LAST[5:0];
    endfunction

    function automatic logic [6:0] ac_idx(input logic [6:0] a);
        return a[6] ? a - LINE2_BASE + 7'(LINE_LEN) : a;
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        return inc ? (a == LINE1_LAST ? LINE2_BASE : a == LINE2_LAST ? LINE1_BASE : a + 7'd1)
                   : (a == LINE1_BASE ? LINE2_LAST : a == LINE2_BASE ? LINE1_LAST : a - 7'd1);
    endfunction
endpackage

// File: rtl/lcd1602_responder_if.sv
// lcd1602_responder_if: LCD1602 parallel bus between an LCD master and the responder.
interface lcd1602_responder_if;
    logic       lcd_EN;
    logic       lcd_RS;
    logic       lcd_RW;
    logic [7:0] lcd_data_in;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe;

    modport master (output lcd_EN, lcd_RS, lcd_RW, lcd_data_in, input lcd_data_out, lcd_data_oe);
    modport slave  (input lcd_EN, lcd_RS, lcd_RW, lcd_data_in, output lcd_data_out, lcd_data_oe);
endinterface

// File: rtl/lcd1602_bus_sync.sv
// lcd1602_bus_sync: 2-flop synchronizers for the LCD bus and EN falling-edge detect; the
// *_p outputs hold RS/RW/data from the cycle before the detected edge.
module lcd1602_bus_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_raw,
    input  logic       rs_raw,
    input  logic       rw_raw,
    input  logic [7:0] data_raw,
    output logic       en,
    output logic       rs,
    output logic       rw,
    output logic       fall,
    output logic       rs_p,
    output logic       rw_p,
    output logic [7:0] data_p
);
    logic [1:0] en_ff, rs_ff, rw_ff;
    logic [7:0] d0, d1;
    logic       en_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_ff  <= '0;
            rs_ff  <= '0;
            rw_ff  <= '0;
            d0     <= '0;
            d1     <= '0;
            en_d   <= 1'b0;
            rs_p   <= 1'b0;
            rw_p   <= 1'b0;
            data_p <= '0;
        end else begin
            en_ff  <= {en_ff[0], en_raw};
            rs_ff  <= {rs_ff[0], rs_raw};
            rw_ff  <= {rw_ff[0], rw_raw};
            d0     <= data_raw;
            d1     <= d0;
            en_d   <= en_ff[1];
            rs_p   <= rs_ff[1];
            rw_p   <= rw_ff[1];
            data_p <= d1;
        end
    end

    assign en   = en_ff[1];
    assign rs   = rs_ff[1];
    assign rw   = rw_ff[1];
    assign fall = en_d & ~en_ff[1];
endmodule

// File: rtl/lcd1602_responder.sv
// lcd1602_responder: HD44780-style LCD1602 bus responder with DDRAM, busy timing and a host peek port.
// Define LCD1602_4BIT_EN to honour DL=0 nibble transfers; without it the bus is always 8-bit.
module lcd1602_responder
    import lcd1602_pkg::*;
#(
    parameter int BUSY_CYCLES  = 2000,
    parameter int CLEAR_CYCLES = 76500
) (
    input  logic               clock_50mhz,
    input  logic               reset_n,
    lcd1602_responder_if.slave bus,
    input  logic [6:0]         rd_addr,
    output logic [7:0]         rd_data,
    output logic               busy,
    output logic [6:0]         ac,
    output logic [2:0]         disp_ctrl,
    output logic               bus_violation
);
    localparam int MAXC = CLEAR_CYCLES > BUSY_CYCLES ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] BUSY_LD  = CW'(BUSY_CYCLES - 1);
    localparam logic [CW-1:0] CLEAR_LD = CW'(CLEAR_CYCLES - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic          sy_en, sy_rs, sy_rw, fall, rs_p, rw_p;
    logic [7:0]    data_p;
    state_e        state;
    logic [CW-1:0] cnt;
    logic [6:0]    sweep_idx;
    logic          id;
    logic [7:0]    ddram [DDRAM_DEPTH];
    logic [7:0]    rdv, rd_out, byte_v, mem_wd;
    logic [6:0]    mem_addr;
    logic          whole, wr_bad, wr_go, ins, dat_wr, dat_rd, mem_we;
    instr_e        op;

    lcd1602_bus_sync u_sync (
        .clk      (clock_50mhz),
        .rst_n    (reset_n),
        .en_raw   (bus.lcd_EN),
        .rs_raw   (bus.lcd_RS),
        .rw_raw   (bus.lcd_RW),
        .data_raw (bus.lcd_data_in),
        .en       (sy_en),
        .rs       (sy_rs),
        .rw       (sy_rw),
        .fall     (fall),
        .rs_p     (rs_p),
        .rw_p     (rw_p),
        .data_p   (data_p)
    );

    assign rdv = sy_rs ? ddram[ac_idx(ac)] : {busy, ac};

`ifdef LCD1602_4BIT_EN
    logic       dl, nib;
    logic [3:0] hi;
    // In nibble mode only the edge carrying the low nibble completes a byte.
    assign whole  = dl | nib;
    assign byte_v = dl ? data_p : {hi, data_p[7:4]};
    assign rd_out = dl ? rdv : nib ? {rdv[3:0], 4'h0} : {rdv[7:4], 4'h0};
`else
    assign whole  = 1'b1;
    assign byte_v = data_p;
    assign rd_out = rdv;
`endif

    assign wr_bad   = fall & ~rw_p & busy;
    assign wr_go    = fall & ~rw_p & ~busy & whole;
    assign ins      = wr_go & ~rs_p;
    assign dat_wr   = wr_go & rs_p;
    assign dat_rd   = fall & rw_p & rs_p & whole;
    assign op       = decode_instr(byte_v);
    assign mem_we   = state == SWEEP || dat_wr;
    assign mem_addr = state == SWEEP ? sweep_idx : ac_idx(ac);
    assign mem_wd   = state == SWEEP ? BLANK : byte_v;

    always_ff @(posedge clock_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            state            <= SWEEP;
            busy             <= 1'b1;
            cnt              <= CLEAR_LD;
            sweep_idx        <= '0;
            ac               <= LINE1_BASE;
            id               <= 1'b1;
            disp_ctrl        <= '0;
            bus_violation    <= 1'b0;
            bus.lcd_data_oe  <= 1'b0;
            bus.lcd_data_out <= '0;
`ifdef LCD1602_4BIT_EN
            dl               <= 1'b1;
            nib              <= 1'b0;
            hi               <= '0;
`endif
        end else begin
            bus.lcd_data_oe  <= sy_en & sy_rw;
            bus.lcd_data_out <= (sy_en & sy_rw) ? rd_out : 8'h00;
            if (wr_bad)
                bus_violation <= 1'b1;
            case (state)
                SWEEP: begin
                    sweep_idx <= sweep_idx + 7'd1;
                    cnt       <= cnt - ONE;
                    if (sweep_idx == 7'(DDRAM_DEPTH - 1))
                        state <= BUSY;
                end
                BUSY: begin
                    cnt <= cnt - ONE;
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: ;
            endcase
            // A data read may land inside a clear window; never shorten it.
            if (dat_rd) begin
                ac   <= ac_step(ac, id);
                busy <= 1'b1;
                cnt  <= (state != IDLE && cnt > BUSY_LD) ? cnt - ONE : BUSY_LD;
                if (state != SWEEP)
                    state <= BUSY;
            end
            if (dat_wr) begin
                ac    <= ac_step(ac, id);
                busy  <= 1'b1;
                cnt   <= BUSY_LD;
                state <= BUSY;
            end
            if (ins) begin
                busy  <= 1'b1;
                cnt   <= BUSY_LD;
                state <= BUSY;
                case (op)
                    I_CLEAR: begin
                        state     <= SWEEP;
                        sweep_idx <= '0;
                        cnt       <= CLEAR_LD;
                        ac        <= LINE1_BASE;
                        id        <= 1'b1;
                    end
                    I_HOME: begin
                        cnt <= CLEAR_LD;
                        ac  <= LINE1_BASE;
                    end
                    I_ENTRY: id <= byte_v[B_ID];
                    I_DISP:  disp_ctrl <= byte_v[2:0];
                    I_SHIFT: if (!byte_v[B_SC]) ac <= ac_step(ac, byte_v[B_RL]);
                    I_DDRAM: if (ac_valid(byte_v[6:0])) ac <= byte_v[6:0]; else bus_violation <= 1'b1;
                    default: ;
                endcase
            end
`ifdef LCD1602_4BIT_EN
            if (fall && !whole && (rw_p || !busy)) begin
                nib <= 1'b1;
                hi  <= data_p[7:4];
            end
            if (fall && whole && (rw_p || !busy))
                nib <= 1'b0;
            if (ins && op == I_FUNC) begin
                dl  <= byte_v[B_DL];
                nib <= 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clock_50mhz)
        if (mem_we)
            ddram[mem_addr] <= mem_wd;

    // Reads the pre-write contents when the peek collides with an internal write.
    always_ff @(posedge clock_50mhz or negedge reset_n)
        if (!reset_n)
            rd_data <= '0;
        else
            rd_data <= rd_addr < 7'(DDRAM_DEPTH) ? ddram[rd_addr] : 8'h00;
endmodule
